// File: rtl/data_mem_lsu_pkg.sv
//==============================================================================
// Module   : data_mem_lsu_pkg
// Brief    : Shared constants, state encoding and helpers for the data_mem LSU.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package data_mem_lsu_pkg;

    localparam int          WORD_W    = 32;
    localparam logic [1:0]  SIZE_BYTE = 2'b00;
    localparam logic [1:0]  SIZE_HALF = 2'b01;
    localparam logic [1:0]  SIZE_WORD = 2'b10;
    localparam logic [31:0] WORD_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_RD   = 2'b01,
        LSU_WR   = 2'b10,
        LSU_RESP = 2'b11
    } lsu_state_t;

    // Encoding 11 behaves exactly like a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? SIZE_WORD : size;
    endfunction

    // Half on an odd byte, or word off a 4-byte boundary.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == SIZE_HALF) && off[0]) || ((size == SIZE_WORD) && (off != 2'b00));
    endfunction

    // Drop the low offset bits that would break natural alignment.
    function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
        logic [1:0] res;
        case (size)
            SIZE_BYTE: res = off;
            SIZE_HALF: res = {off[1], 1'b0};
            default:   res = 2'b00;
        endcase
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_lsu_lane.sv
//==============================================================================
// Module   : data_mem_lsu_lane
// Brief    : Big-endian lane extraction with sign/zero extension, and sub-word
//            store merge into a previously read word. Purely combinational.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module data_mem_lsu_lane
    import data_mem_lsu_pkg::*;
(
    input  logic [WORD_W-1:0] w,
    input  logic [WORD_W-1:0] wdata,
    input  logic [1:0]        off,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] merged_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed lane, extend it for loads, splice wdata into it for stores.
    always_comb begin
        w_byte      = 8'h00;
        w_half      = off[1] ? w[15:0] : w[31:16];
        load_data   = w;
        merged_word = w;
        case (off)
            2'd0:    w_byte = w[31:24];
            2'd1:    w_byte = w[23:16];
            2'd2:    w_byte = w[15:8];
            default: w_byte = w[7:0];
        endcase
        case (size)
            SIZE_BYTE: begin
                load_data = {{24{sign_ext & w_byte[7]}}, w_byte};
                case (off)
                    2'd0:    merged_word[31:24] = wdata[7:0];
                    2'd1:    merged_word[23:16] = wdata[7:0];
                    2'd2:    merged_word[15:8]  = wdata[7:0];
                    default: merged_word[7:0]   = wdata[7:0];
                endcase
            end
            SIZE_HALF: begin
                load_data = {{16{sign_ext & w_half[15]}}, w_half};
                if (off[1]) merged_word[15:0]  = wdata[15:0];
                else        merged_word[31:16] = wdata[15:0];
            end
            default: begin
                load_data   = w;
                merged_word = wdata;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/data_mem_lsu.sv
//==============================================================================
// Module   : data_mem_lsu
// Brief    : Load/store unit driving the data_mem interface. One request at a
//            time; sub-word stores use read-modify-write; one resp_valid pulse
//            per accepted request.
// Config   : LSU_MISALIGN_TRAP_EN - misaligned requests skip memory and return
//            resp_err=1. Undefined: misaligned addresses are force-aligned.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module data_mem_lsu
    import data_mem_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              mem_read,
    output logic              mem_write
);

    lsu_state_t        r_state;
    lsu_state_t        w_state_nxt;
    logic              r_we;
    logic              r_signed;
    logic [1:0]        r_size;
    logic [1:0]        r_off;
    logic [DATA_W-1:0] r_wdata;

    logic              w_accept;
    logic [1:0]        w_size;
    logic [1:0]        w_off;
    logic              w_trap;
    logic [DATA_W-1:0] w_load_data;
    logic [DATA_W-1:0] w_merged_word;

    assign w_accept = req_valid & (r_state == LSU_IDLE);
    assign w_size   = norm_size(req_size);
    assign w_off    = align_off(w_size, req_addr[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_err;
    assign w_trap   = is_misaligned(w_size, req_addr[1:0]);
    assign resp_err = r_err & (r_state == LSU_RESP);

    // Remember whether the accepted request trapped on alignment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_err <= 1'b0;
        else if (w_accept) r_err <= w_trap;
    end
`else
    assign w_trap   = 1'b0;
    assign resp_err = 1'b0;
`endif

    // Handshake and strobes decode straight from state so they drop on reset.
    assign req_ready  = (r_state == LSU_IDLE);
    assign mem_read   = (r_state == LSU_RD);
    assign mem_write  = (r_state == LSU_WR);
    assign resp_valid = (r_state == LSU_RESP);

    data_mem_lsu_lane u_lane (
        .w           (mem_read_data),
        .wdata       (r_wdata),
        .off         (r_off),
        .size        (r_size),
        .sign_ext    (r_signed),
        .load_data   (w_load_data),
        .merged_word (w_merged_word)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= LSU_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state decode: word stores skip the read, sub-word stores read first.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LSU_IDLE: begin
                if (req_valid) begin
                    if (w_trap)                             w_state_nxt = LSU_RESP;
                    else if (req_we && w_size == SIZE_WORD) w_state_nxt = LSU_WR;
                    else                                    w_state_nxt = LSU_RD;
                end
            end
            LSU_RD:   w_state_nxt = r_we ? LSU_WR : LSU_RESP;
            LSU_WR:   w_state_nxt = LSU_RESP;
            LSU_RESP: w_state_nxt = LSU_IDLE;
            default:  w_state_nxt = LSU_IDLE;
        endcase
    end

    // Request latches and memory/response data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we           <= 1'b0;
            r_signed       <= 1'b0;
            r_size         <= SIZE_BYTE;
            r_off          <= 2'b00;
            r_wdata        <= WORD_ZERO;
            mem_address    <= WORD_ZERO;
            mem_write_data <= WORD_ZERO;
            resp_rdata     <= WORD_ZERO;
        end else begin
            if (w_accept) begin
                r_we           <= req_we;
                r_signed       <= req_signed;
                r_size         <= w_size;
                r_off          <= w_off;
                r_wdata        <= req_wdata;
                mem_address    <= {req_addr[ADDR_W-1:2], 2'b00};
                // A word store writes this directly; sub-word stores overwrite it after the read.
                mem_write_data <= req_wdata;
                if (w_trap) resp_rdata <= WORD_ZERO;
            end
            case (r_state)
                LSU_RD: begin
                    if (r_we) mem_write_data <= w_merged_word;
                    else      resp_rdata     <= w_load_data;
                end
                LSU_WR:  resp_rdata <= WORD_ZERO;
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_lsu.sv
//==============================================================================
// Module   : tb_data_mem_lsu
// Brief    : Self-checking bench for data_mem_lsu with a small word memory
//            model and a response scoreboard.
// Config   : LSU_MISALIGN_TRAP_EN selects the trapping expectations.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_data_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    wire  [31:0] mem_read_data;
    logic        mem_read;
    logic        mem_write;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_resp = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
        int          id;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    int   next_id = 0;

    logic [31:0] memw [0:15];
    logic        poke_en  = 1'b0;
    logic [3:0]  poke_idx = 4'd0;
    logic [31:0] poke_val = 32'h0;

    data_mem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write)
    );

    always #5 clk = ~clk;

    // Cycle counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // Word memory: DUT writes commit on the posedge; the bench preloads through the poke port.
    always @(posedge clk) begin
        if (mem_write) memw[mem_address[5:2]] <= mem_write_data;
        if (poke_en)   memw[poke_idx]         <= poke_val;
    end
    assign mem_read_data = mem_read ? memw[mem_address[5:2]] : 32'bz;

    // Strobe activity counters.
    always @(negedge clk) begin
        if (mem_read)  rd_cnt++;
        if (mem_write) wr_cnt++;
    end

    // Scoreboard: every resp_valid pops one expectation.
    always @(negedge clk) begin
        if (resp_valid) begin
            n_resp++;
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_resp: observed resp_valid=1 rdata %h, expected no response", resp_rdata);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                assert (resp_rdata === e.rdata) else begin
                    errors++;
                    $error("FAIL rdata_req%0d: observed %h expected %h", e.id, resp_rdata, e.rdata);
                end
                checks++;
                assert (resp_err === e.err) else begin
                    errors++;
                    $error("FAIL err_req%0d: observed %b expected %b", e.id, resp_err, e.err);
                end
                checks++;
                assert ((cyc - e.acc) == e.lat) else begin
                    errors++;
                    $error("FAIL latency_req%0d: observed %0d expected %0d", e.id, cyc - e.acc, e.lat);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [3:0] idx, input logic [31:0] val);
        @(negedge clk);
        poke_en  = 1'b1;
        poke_idx = idx;
        poke_val = val;
        @(negedge clk);
        poke_en  = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] rdata, input logic err, input int lat);
        exp_t x;
        x.rdata = rdata;
        x.err   = err;
        x.acc   = cyc - 1;
        x.lat   = lat;
        x.id    = next_id;
        next_id++;
        sb.push_back(x);
    endtask

    // Present one request, wait for acceptance, register its expected response.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input int lat);
        int n;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $error("FAIL accept_timeout: observed req_ready=0 expected 1");
        end
        @(posedge clk);
        #1;
        push_exp(exp_rdata, exp_err, lat);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || !req_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $error("FAIL resp_timeout: observed %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0;
        int w0;
        int c0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;

        poke(4'd0,  32'hA1B2C3D4);
        poke(4'd1,  32'h12345678);
        poke(4'd2,  32'h11223344);
        poke(4'd11, 32'h00000000);

        // Reset state
        chk("rst_ready",      {31'b0, req_ready},  32'h1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_strobes",    {30'b0, mem_read, mem_write}, 32'h0);
        chk("rst_mem_addr",   mem_address,    32'h0);
        chk("rst_mem_wdata",  mem_write_data, 32'h0);
        chk("rst_rdata",      resp_rdata,     32'h0);
        chk("rst_err",        {31'b0, resp_err}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // 1: word load at 4
        do_req(1'b0, 2'b10, 1'b0, 32'd4, 32'h0, 32'h12345678, 1'b0, 2);
        chk("t1_mem_addr", mem_address, 32'd4);
        chk("t1_mem_read", {31'b0, mem_read}, 32'h1);
        wait_idle();

        // 2: byte loads at 5, signed and unsigned
        poke(4'd1, 32'h129A5678);
        do_req(1'b0, 2'b00, 1'b1, 32'd5, 32'h0, 32'hFFFFFF9A, 1'b0, 2);
        wait_idle();
        do_req(1'b0, 2'b00, 1'b0, 32'd5, 32'h0, 32'h0000009A, 1'b0, 2);
        wait_idle();

        // 3: half store BEEF at 6 (read-modify-write)
        poke(4'd1, 32'h12345678);
        w0 = wr_cnt;
        r0 = rd_cnt;
        do_req(1'b1, 2'b01, 1'b0, 32'd6, 32'h0000BEEF, 32'h0, 1'b0, 3);
        wait_idle();
        chk("t3_mem_word", memw[1], 32'h1234BEEF);
        chk("t3_wr_cycles", wr_cnt - w0, 32'd1);
        chk("t3_rd_cycles", rd_cnt - r0, 32'd1);
        do_req(1'b0, 2'b01, 1'b1, 32'd6, 32'h0, 32'hFFFFBEEF, 1'b0, 2);
        wait_idle();
        do_req(1'b0, 2'b00, 1'b0, 32'd7, 32'h0, 32'h000000EF, 1'b0, 2);
        wait_idle();
        do_req(1'b0, 2'b11, 1'b0, 32'd4, 32'h0, 32'h1234BEEF, 1'b0, 2);
        wait_idle();

        // 4: word store at 44, then byte store merge at 45
        w0 = wr_cnt;
        r0 = rd_cnt;
        do_req(1'b1, 2'b10, 1'b0, 32'd44, 32'hFFFF0000, 32'h0, 1'b0, 2);
        wait_idle();
        chk("t4_wr_cycles", wr_cnt - w0, 32'd1);
        chk("t4_rd_cycles", rd_cnt - r0, 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'd44, 32'h0, 32'hFFFF0000, 1'b0, 2);
        wait_idle();
        do_req(1'b1, 2'b00, 1'b0, 32'd45, 32'h0000005A, 32'h0, 1'b0, 3);
        wait_idle();
        do_req(1'b0, 2'b10, 1'b0, 32'd44, 32'h0, 32'hFF5A0000, 1'b0, 2);
        wait_idle();

        // 5: req_valid held while busy
        c0 = n_resp;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_size   = 2'b10;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        @(posedge clk);
        #1;
        push_exp(32'hA1B2C3D4, 1'b0, 2);
        req_size = 2'b00;
        req_addr = 32'd1;
        chk("t5_busy_rd", {31'b0, req_ready}, 32'h0);
        @(posedge clk);
        #1;
        chk("t5_busy_resp", {31'b0, req_ready}, 32'h0);
        @(posedge clk);
        #1;
        chk("t5_idle_ready", {31'b0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        push_exp(32'h000000B2, 1'b0, 2);
        req_valid = 1'b0;
        chk("t5_accepted", {31'b0, req_ready}, 32'h0);
        wait_idle();
        chk("t5_resp_count", n_resp - c0, 32'd2);

        // 6: reset during the write cycle of a word store to 8
        c0 = n_resp;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_size   = 2'b10;
        req_addr   = 32'd8;
        req_wdata  = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("t6_in_wr", {31'b0, mem_write}, 32'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_wr_drop", {31'b0, mem_write}, 32'h0);
        chk("t6_ready",   {31'b0, req_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_mem_kept",  memw[2], 32'h11223344);
        chk("t6_no_resp",   n_resp - c0, 32'd0);

        // 7: half load at misaligned address 3
        r0 = rd_cnt;
`ifdef LSU_MISALIGN_TRAP_EN
        do_req(1'b0, 2'b01, 1'b0, 32'd3, 32'h0, 32'h0, 1'b1, 1);
        wait_idle();
        chk("t7_no_read", rd_cnt - r0, 32'd0);
`else
        do_req(1'b0, 2'b01, 1'b0, 32'd3, 32'h0, 32'h0000C3D4, 1'b0, 2);
        wait_idle();
        chk("t7_one_read", rd_cnt - r0, 32'd1);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
